// File: rtl/xyolo_pkg.sv
// Shared definitions for the xyolo lane sequencer: FSM encoding, maxpool
// window size and the field layout of the multiplier-latency tag.
package xyolo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MP_WIN        = 4;
    localparam int TAG_W         = 3;
    localparam int TAG_GRP_LAST  = 2;
    localparam int TAG_WIN_FIRST = 1;
    localparam int TAG_WIN_LAST  = 0;

endpackage

// File: rtl/xyolo_tag_dly.sv
// Valid+tag shift line matching the multiplier pipeline; the tap is either at
// full depth or at depth 1 (bypass). pend covers every stage up to the tap.
module xyolo_tag_dly #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             short_tap,
    output logic             tap_vld,
    output logic [TAG_W-1:0] tap_tag,
    output logic             pend
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    always_comb begin
        vld_d    = {vld_q[DEPTH-2:0], push};
        tag_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        if (clr) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tap_vld = short_tap ? vld_q[0] : vld_q[DEPTH-1];
    assign tap_tag = short_tap ? tag_q[0] : tag_q[DEPTH-1];
    assign pend    = short_tap ? vld_q[0] : (|vld_q);

endmodule

// File: rtl/xyolo_seq.sv
// Layer sequencer for one xyolo conv/maxpool lane.
// state | meaning: IDLE wait for run | RUN issue operands | DRAIN flush multiplier | DONE end pulse
module xyolo_seq
    import xyolo_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [LEN_W-1:0]   cfg_acc_len,
    input  logic [CNT_W-1:0]   cfg_n_out,
    input  logic               cfg_bias,
    input  logic               cfg_leaky,
    input  logic               cfg_maxpool,
    input  logic               cfg_bypass,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic               busy,
    output logic               done,
    output logic               op_en,
    output logic               ld_acc,
    output logic               ld_mp,
    output logic               ld_res,
    output logic               bias,
    output logic               leaky,
    output logic               maxpool,
    output logic               bypass,
    output logic [SHIFT_W-1:0] shift,
    output logic               out_valid
);

    localparam int WIN_W = $clog2(MP_WIN);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   acc_cnt_q, acc_cnt_d, acc_last_q, acc_last_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d, n_out_q, n_out_d;
    logic               bias_q, bias_d, leaky_q, leaky_d;
    logic               maxpool_q, maxpool_d, bypass_q, bypass_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               out_valid_q, out_valid_d;

    logic               acc_last, win_last, out_last;
    logic               tap_vld, pend;
    logic [TAG_W-1:0]   tap_tag, tag_in;

    assign acc_last = (acc_cnt_q == acc_last_q);
    assign win_last = !maxpool_q || (win_cnt_q == WIN_W'(MP_WIN - 1));
    assign out_last = (out_cnt_q == n_out_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_cnt_q   <= '0;
            win_cnt_q   <= '0;
            out_cnt_q   <= '0;
            acc_last_q  <= '0;
            n_out_q     <= '0;
            bias_q      <= 1'b0;
            leaky_q     <= 1'b0;
            maxpool_q   <= 1'b0;
            bypass_q    <= 1'b0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            win_cnt_q   <= win_cnt_d;
            out_cnt_q   <= out_cnt_d;
            acc_last_q  <= acc_last_d;
            n_out_q     <= n_out_d;
            bias_q      <= bias_d;
            leaky_q     <= leaky_d;
            maxpool_q   <= maxpool_d;
            bypass_q    <= bypass_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
        end
    end

    // An empty layer takes the DRAIN path; with nothing in flight it exits at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = (cfg_n_out == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (acc_last && win_last && out_last) state_d = ST_DRAIN;
            ST_DRAIN: if (!pend) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        win_cnt_d = win_cnt_q;
        out_cnt_d = out_cnt_q;
        if (state_q != ST_RUN) begin
            acc_cnt_d = '0;
            win_cnt_d = '0;
            out_cnt_d = '0;
        end else if (acc_last) begin
            acc_cnt_d = '0;
            if (win_last) begin
                win_cnt_d = '0;
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
            end
        end else begin
            acc_cnt_d = acc_cnt_q + LEN_W'(1);
        end
    end

    // Stored as L-1 so the group-end compare never needs an adder.
    always_comb begin
        acc_last_d = acc_last_q;
        n_out_d    = n_out_q;
        bias_d     = bias_q;
        leaky_d    = leaky_q;
        maxpool_d  = maxpool_q;
        bypass_d   = bypass_q;
        shift_d    = shift_q;
        if (state_q == ST_IDLE && run) begin
            acc_last_d = (cfg_bypass || cfg_acc_len == '0) ? '0 : cfg_acc_len - LEN_W'(1);
            n_out_d    = cfg_n_out;
            bias_d     = cfg_bias;
            leaky_d    = cfg_leaky;
            maxpool_d  = cfg_maxpool;
            bypass_d   = cfg_bypass;
            shift_d    = cfg_shift;
        end
    end

    always_comb begin
        tag_in                = '0;
        tag_in[TAG_GRP_LAST]  = acc_last;
        tag_in[TAG_WIN_FIRST] = (win_cnt_q == '0);
        tag_in[TAG_WIN_LAST]  = win_last;
    end

    xyolo_tag_dly #(
        .DEPTH (MUL_LAT),
        .TAG_W (TAG_W)
    ) u_tag_dly (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == ST_DONE),
        .push      (op_en),
        .tag_in    (tag_in),
        .short_tap (bypass_q),
        .tap_vld   (tap_vld),
        .tap_tag   (tap_tag),
        .pend      (pend)
    );

    always_comb begin
        op_en       = (state_q == ST_RUN);
        ld_acc      = op_en && (acc_cnt_q == '0) && !bypass_q;
        ld_res      = tap_vld && tap_tag[TAG_GRP_LAST];
        ld_mp       = ld_res && maxpool_q && !tap_tag[TAG_WIN_FIRST];
        out_valid_d = ld_res && tap_tag[TAG_WIN_LAST];
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
    end

    assign out_valid = out_valid_q;
    assign bias      = bias_q;
    assign leaky     = leaky_q;
    assign maxpool   = maxpool_q;
    assign bypass    = bypass_q;
    assign shift     = shift_q;

endmodule

// File: tb/tb_xyolo_seq.sv
// Scoreboard bench for xyolo_seq: per-cycle expected control vectors are queued
// before each layer and a negedge monitor pops one whenever any control is high.
module tb_xyolo_seq;

    localparam int SHIFT_W = 5;
    localparam int B_OP = 0, B_ACC = 1, B_MP = 2, B_RES = 3, B_OV = 4, B_DONE = 5, B_BUSY = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               run = 1'b0;
    logic [15:0]        cfg_acc_len = '0;
    logic [15:0]        cfg_n_out = '0;
    logic               cfg_bias = 1'b0, cfg_leaky = 1'b0, cfg_maxpool = 1'b0, cfg_bypass = 1'b0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               busy, done, op_en, ld_acc, ld_mp, ld_res, out_valid;
    logic               bias, leaky, maxpool, bypass;
    logic [SHIFT_W-1:0] shift;

    xyolo_seq #(.MUL_LAT(4), .LEN_W(16), .CNT_W(16), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst(rst), .run(run),
        .cfg_acc_len(cfg_acc_len), .cfg_n_out(cfg_n_out),
        .cfg_bias(cfg_bias), .cfg_leaky(cfg_leaky), .cfg_maxpool(cfg_maxpool),
        .cfg_bypass(cfg_bypass), .cfg_shift(cfg_shift),
        .busy(busy), .done(done), .op_en(op_en), .ld_acc(ld_acc), .ld_mp(ld_mp),
        .ld_res(ld_res), .bias(bias), .leaky(leaky), .maxpool(maxpool),
        .bypass(bypass), .shift(shift), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [6:0] v;
    } ev_t;

    ev_t        sbq[$];
    ev_t        mon_e;
    logic [6:0] exp_tab [64];
    int         cyc = 0;
    int         base = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         op_cnt = 0;
    int         ov_cnt = 0;
    logic       sb_en = 1'b0;
    logic [6:0] obs;

    assign obs = {busy, done, out_valid, ld_res, ld_mp, ld_acc, op_en};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (op_en) op_cnt++;
        if (out_valid) ov_cnt++;
        if (sb_en && obs != 7'd0) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ctrl cyc=%0d got=%b required=none", cyc - base, obs);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.c != cyc - base || mon_e.v != obs) begin
                    n_fail++;
                    $display("FAIL ctrl_vec got cyc=%0d vec=%b required cyc=%0d vec=%b",
                             cyc - base, obs, mon_e.c, mon_e.v);
                end
            end
        end
    end

    task automatic clr_tab();
        for (int i = 0; i < 64; i++) exp_tab[i] = '0;
    endtask

    task automatic set_rng(input int b, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_tab[i][b] = 1'b1;
    endtask

    task automatic load_sb();
        for (int i = 0; i < 64; i++)
            if (exp_tab[i] != '0) sbq.push_back('{i, exp_tab[i]});
    endtask

    task automatic start(input logic [15:0] len, input logic [15:0] n, input logic b,
                         input logic l, input logic m, input logic y,
                         input logic [SHIFT_W-1:0] sh);
        @(negedge clk);
        cfg_acc_len = len; cfg_n_out = n; cfg_bias = b; cfg_leaky = l;
        cfg_maxpool = m; cfg_bypass = y; cfg_shift = sh;
        run  = 1'b1;
        base = cyc;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - base < rel) @(negedge clk);
    endtask

    task automatic check_empty(input string nm);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s pending_events got=%0d required=0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check_cfg(input string nm, input logic [3+SHIFT_W:0] req);
        n_chk++;
        if ({bias, leaky, maxpool, bypass, shift} !== req) begin
            n_fail++;
            $display("FAIL %s cfg got=%b required=%b", nm, {bias, leaky, maxpool, bypass, shift}, req);
        end
    endtask

    task automatic plain_tab();
        clr_tab();
        set_rng(B_BUSY, 1, 12); set_rng(B_OP, 1, 6);
        set_rng(B_ACC, 1, 1);   set_rng(B_ACC, 4, 4);
        set_rng(B_RES, 7, 7);   set_rng(B_RES, 10, 10);
        set_rng(B_OV, 8, 8);    set_rng(B_OV, 11, 11);
        set_rng(B_DONE, 12, 12);
        load_sb();
    endtask

    task automatic maxpool_tab();
        clr_tab();
        set_rng(B_BUSY, 1, 10); set_rng(B_OP, 1, 4); set_rng(B_ACC, 1, 4);
        set_rng(B_RES, 5, 8);   set_rng(B_MP, 6, 8); set_rng(B_OV, 9, 9);
        set_rng(B_DONE, 10, 10);
        load_sb();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        n_chk++;
        if ({obs, bias, leaky, maxpool, bypass, shift} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b required=0", {obs, bias, leaky, maxpool, bypass, shift});
        end
        rst = 1'b0;
        sb_en = 1'b1;
        repeat (2) @(negedge clk);

        plain_tab();
        start(16'd3, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
        wait_rel(16);
        check_empty("plain");
        check_cfg("plain", {1'b1, 1'b0, 1'b0, 1'b0, 5'd7});

        maxpool_tab();
        start(16'd1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3);
        wait_rel(14);
        check_empty("maxpool");
        check_cfg("maxpool", {1'b0, 1'b1, 1'b1, 1'b0, 5'd3});

        clr_tab();
        set_rng(B_BUSY, 1, 6); set_rng(B_OP, 1, 3); set_rng(B_RES, 2, 4);
        set_rng(B_OV, 3, 5);   set_rng(B_DONE, 6, 6);
        load_sb();
        start(16'd7, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
        wait_rel(10);
        check_empty("bypass");
        check_cfg("bypass", {1'b0, 1'b0, 1'b0, 1'b1, 5'd1});

        clr_tab();
        set_rng(B_BUSY, 1, 2); set_rng(B_DONE, 2, 2);
        load_sb();
        start(16'd5, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9);
        wait_rel(6);
        check_empty("zero_n_out");

        clr_tab();
        set_rng(B_BUSY, 1, 7); set_rng(B_OP, 1, 1); set_rng(B_ACC, 1, 1);
        set_rng(B_RES, 5, 5);  set_rng(B_OV, 6, 6); set_rng(B_DONE, 7, 7);
        load_sb();
        start(16'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
        wait_rel(11);
        check_empty("zero_acc_len");

        clr_tab();
        set_rng(B_BUSY, 1, 22); set_rng(B_OP, 1, 16);
        for (int i = 1; i <= 15; i += 2) set_rng(B_ACC, i, i);
        for (int i = 6; i <= 20; i += 2) set_rng(B_RES, i, i);
        set_rng(B_MP, 8, 8);   set_rng(B_MP, 10, 10); set_rng(B_MP, 12, 12);
        set_rng(B_MP, 16, 16); set_rng(B_MP, 18, 18); set_rng(B_MP, 20, 20);
        set_rng(B_OV, 13, 13); set_rng(B_OV, 21, 21); set_rng(B_DONE, 22, 22);
        load_sb();
        start(16'd2, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
        wait_rel(26);
        check_empty("maxpool_2x2");

        plain_tab();
        start(16'd3, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
        wait_rel(3);
        cfg_acc_len = 16'd9; cfg_n_out = 16'd5; cfg_bias = 1'b0; cfg_leaky = 1'b1;
        cfg_maxpool = 1'b1; cfg_bypass = 1'b1; cfg_shift = 5'd30;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_rel(16);
        check_empty("run_while_busy");
        check_cfg("run_while_busy", {1'b1, 1'b0, 1'b0, 1'b0, 5'd7});

        clr_tab();
        set_rng(B_BUSY, 1, 5); set_rng(B_OP, 1, 4); set_rng(B_ACC, 1, 4); set_rng(B_RES, 5, 5);
        load_sb();
        start(16'd1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        wait_rel(5);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({obs, bias, leaky, maxpool, bypass, shift} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_layer got=%b required=0", {obs, bias, leaky, maxpool, bypass, shift});
        end
        rst = 1'b0;
        wait_rel(20);
        check_empty("reset_mid_layer");

        plain_tab();
        start(16'd3, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
        wait_rel(16);
        check_empty("fresh_run");

        sb_en  = 1'b0;
        op_cnt = 0;
        ov_cnt = 0;
        start(16'd4, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        for (int k = 0; k < 70000 && !done; k++) @(negedge clk);
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL max_n_out_timeout done got=0 required=1");
        end
        n_chk++;
        if (op_cnt != 65535 || ov_cnt != 65535) begin
            n_fail++;
            $display("FAIL max_n_out_counts got op_en=%0d out_valid=%0d required 65535 each", op_cnt, ov_cnt);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
